// File: rtl/mem_rw_responder_if.sv
// Request/response bus between a requester and mem_rw_responder.
// With `WR_RESP_EN defined, the bus also carries rsp_is_wr.
interface mem_rw_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              wr_done;
`ifdef WR_RESP_EN
  logic              rsp_is_wr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, wr_done, rsp_is_wr
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, wr_done, rsp_is_wr
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, wr_done
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, wr_done
  );
`endif
endinterface

// File: rtl/mem_rw_responder.sv
// Handshaked single-outstanding memory responder with a fixed read latency.
// Optional `WR_RESP_EN: writes are also answered on the response channel and flagged with rsp_is_wr.
module mem_rw_responder #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 2
) (
  input  logic     clk,
  input  logic     rst,
  mem_rw_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RSP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              wr_done_q, wr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              req_ready;
  logic              accept;
  logic              wr_en;
`ifdef WR_RESP_EN
  logic              is_wr_q, is_wr_d;
`endif

  assign accept = bus.req_valid & req_ready;
  assign wr_en  = accept & bus.req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
`ifdef WR_RESP_EN
      is_wr_q     <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
`ifdef WR_RESP_EN
      is_wr_q     <= is_wr_d;
`endif
      if (wr_en) mem_q[bus.req_addr] <= bus.req_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    wr_done_d   = wr_en;
`ifdef WR_RESP_EN
    is_wr_d     = is_wr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.req_we) begin
`ifdef WR_RESP_EN
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rdata_d     = bus.req_wdata;
            is_wr_d     = 1'b1;
`endif
          end else begin
            // Counter preload makes rsp_valid rise exactly RD_LAT edges after acceptance.
            addr_d  = bus.req_addr;
            cnt_d   = 4'(RD_LAT - 1);
            state_d = RD_WAIT;
`ifdef WR_RESP_EN
            is_wr_d = 1'b0;
`endif
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d     = mem_q[addr_q];
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE) && !rst;
    bus.req_ready = req_ready;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_rdata = rdata_q;
    bus.wr_done   = wr_done_q;
`ifdef WR_RESP_EN
    bus.rsp_is_wr = is_wr_q;
`endif
  end

endmodule

// File: tb/tb_mem_rw_responder.sv
// Scoreboard bench for mem_rw_responder: a model memory predicts read data,
// expected responses are queued at issue and popped when rsp_valid appears.
module tb_mem_rw_responder;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_rw_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  mem_rw_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] model_mem [4];
  logic [DATA_W-1:0] exp_q [$];

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    model_mem[a] = d;
`ifdef WR_RESP_EN
    bus.rsp_ready = 1'b1;
    if (bus.rsp_valid) begin @(posedge clk); #1; end
`endif
  endtask

  // Issues a read, returns the observed data and cycles from acceptance to rsp_valid.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                         output int lat, output bit ok);
    ok = 1'b1; lat = 0; d = '0;
    wait_ready();
    if (!bus.req_ready) begin ok = 1'b0; return; end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
    exp_q.push_back(model_mem[a]);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.rsp_valid) begin ok = 1'b0; return; end
    d = bus.rsp_rdata;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d, e;
    int lat;
    bit ok;
    do_write(2'd0, 4'hC);
    do_read(2'd0, d, lat, ok);
    e = exp_q.pop_front();
    n_vec++;
    if (!ok || d !== e) begin n_err++; $display("FAIL pre_reset_read: got %h expected %h", d, e); end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_vec++;
    if (bus.wr_done !== 1'b0) begin n_err++; $display("FAIL reset_wr_done: got %b expected 0", bus.wr_done); end
    n_vec++;
    if (bus.rsp_rdata !== 4'h0) begin n_err++; $display("FAIL reset_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
    n_vec++;
    if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    #1 rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), d, lat, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || d !== e) begin n_err++; $display("FAIL reset_read_%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] wd [4];
    logic [DATA_W-1:0] d, e;
    int lat;
    bit ok;
    wd = '{4'hA, 4'h3, 4'hF, 4'h5};
`ifdef WR_RESP_EN
    for (int i = 0; i < 4; i++) do_write(2'(i), wd[i]);
`else
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr = 2'(i); bus.req_wdata = wd[i];
      n_vec++;
      if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.req_ready); end
      @(posedge clk); #1;
      model_mem[i] = wd[i];
      n_vec++;
      if (bus.wr_done !== 1'b1) begin n_err++; $display("FAIL b2b_wr_done_%0d: got %b expected 1", i, bus.wr_done); end
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.wr_done !== 1'b0) begin n_err++; $display("FAIL b2b_wr_done_end: got %b expected 0", bus.wr_done); end
`endif
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), d, lat, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || d !== e) begin n_err++; $display("FAIL b2b_read_%0d: got %h expected %h", i, d, e); end
      n_vec++;
      if (lat != RD_LAT) begin n_err++; $display("FAIL b2b_latency_%0d: got %0d expected %0d", i, lat, RD_LAT); end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d, e;
    int lat;
    int n;
    bit ok;
    wait_ready();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 2'd2;
    exp_q.push_back(model_mem[2]);
    @(posedge clk); #1;
    // A write presented while busy must be ignored.
    bus.req_we = 1'b1; bus.req_addr = 2'd0; bus.req_wdata = 4'h0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    n_vec++;
    if (!bus.rsp_valid) begin n_err++; $display("FAIL bp_timeout: got rsp_valid 0 expected 1"); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e || bus.req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b expected valid=1 data=%h ready=0",
                 k, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, e);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== e) begin
      n_err++;
      $display("FAIL bp_release: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=%h",
               bus.rsp_valid, bus.req_ready, bus.rsp_rdata, e);
    end
    do_read(2'd0, d, lat, ok);
    e = exp_q.pop_front();
    n_vec++;
    if (!ok || d !== e) begin n_err++; $display("FAIL bp_ignored_write: got %h expected %h", d, e); end
  endtask

  task automatic test_raw();
    logic [DATA_W-1:0] d, e;
    int lat;
    bit ok;
    do_write(2'd1, 4'h9);
    do_read(2'd1, d, lat, ok);
    e = exp_q.pop_front();
    n_vec++;
    if (!ok || d !== e) begin n_err++; $display("FAIL raw_read: got %h expected %h", d, e); end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] d, e;
    int lat;
    int n;
    bit ok;
    do_write(2'd3, 4'h7);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_err++; $display("FAIL rdwait_rst: got valid=%b ready=%b expected 0 0", bus.rsp_valid, bus.req_ready);
    end
    #1 rst = 1'b0;
    clear_model();
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rdwait_idle: got ready=%b expected 1", bus.req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rdwait_no_rsp_%0d: got %b expected 0", k, bus.rsp_valid); end
    end
    do_read(2'd3, d, lat, ok);
    e = exp_q.pop_front();
    n_vec++;
    if (!ok || d !== e) begin n_err++; $display("FAIL rdwait_cleared: got %h expected %h", d, e); end
    // Reset while a response is being held.
    do_write(2'd2, 4'h6);
    wait_ready();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 2'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 4'h6) begin
      n_err++; $display("FAIL rsp_before_rst: got valid=%b data=%h expected 1 6", bus.rsp_valid, bus.rsp_rdata);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 4'h0) begin
      n_err++; $display("FAIL rsp_rst: got valid=%b data=%h expected 0 0", bus.rsp_valid, bus.rsp_rdata);
    end
    #1 rst = 1'b0;
    clear_model();
    bus.rsp_ready = 1'b1;
    do_read(2'd2, d, lat, ok);
    e = exp_q.pop_front();
    n_vec++;
    if (!ok || d !== e) begin n_err++; $display("FAIL rsp_rst_cleared: got %h expected %h", d, e); end
  endtask

`ifdef WR_RESP_EN
  task automatic test_wr_resp();
    logic [DATA_W-1:0] d, e;
    int lat;
    bit ok;
    wait_ready();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 2'd3; bus.req_wdata = 4'h6;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    model_mem[3] = 4'h6;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 4'h6 || bus.rsp_is_wr !== 1'b1 ||
        bus.req_ready !== 1'b0 || bus.wr_done !== 1'b1) begin
      n_err++;
      $display("FAIL wr_resp: got valid=%b data=%h is_wr=%b ready=%b done=%b expected 1 6 1 0 1",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_is_wr, bus.req_ready, bus.wr_done);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    do_read(2'd3, d, lat, ok);
    e = exp_q.pop_front();
    n_vec++;
    if (!ok || d !== e || bus.rsp_is_wr !== 1'b0) begin
      n_err++; $display("FAIL wr_resp_read: got %h is_wr=%b expected %h is_wr=0", d, bus.rsp_is_wr, e);
    end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    clear_model();
    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_raw();
    test_async_reset();
`ifdef WR_RESP_EN
    test_wr_resp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rw_responder.md
Name: mem_rw_responder

Overview:
- Synchronous, handshaked memory responder: the target/slave end of the read/write memory interface our initiators and benches drive.
- Accepts one request at a time (write or read) over valid/ready, stores words in an internal flop array, returns read data over a separate valid/ready response channel after a fixed latency.
- Sits between any requester (bench, BIST, bus bridge) and local storage; replaces the unhandshaked asynchronous RAM wherever back-pressure is needed.

Parameters:
- DATA_W, 4, data word width in bits.
- ADDR_W, 2, address width; depth = 2**ADDR_W words.
- RD_LAT, 2, cycles from read acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read; sampled on acceptance.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response data valid.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_W  read data.
- wr_done  output  1  one-cycle pulse, the cycle after a write is accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=0 while rst high, rsp_valid=0, rsp_rdata=0, wr_done=0, latency counter=0, all memory words cleared to 0.
- Acceptance: request accepted on a rising edge where req_valid & req_ready. req_ready = 1 only in IDLE (and not in reset).
- States: IDLE, RD_WAIT, RSP.
- IDLE + accepted write: mem[req_addr] <= req_wdata on that edge; wr_done=1 next cycle only; stay IDLE (back-to-back writes at 1 per cycle).
- IDLE + accepted read: capture address, load counter with RD_LAT-1, go to RD_WAIT; req_ready=0 from next cycle.
- RD_WAIT: decrement counter each cycle; when counter==0, register rsp_rdata <= mem[captured addr], rsp_valid <= 1, go to RSP. Net: rsp_valid rises exactly RD_LAT cycles after the acceptance edge.
- RSP: rsp_valid and rsp_rdata held stable until rsp_valid & rsp_ready on an edge; then rsp_valid <= 0, go IDLE; req_ready is 1 the following cycle (no same-cycle turnaround).
- rsp_rdata holds the last read value after handshake (not cleared).
- Read data reflects memory at the RD_WAIT exit edge; no writes can occur meanwhile, so read-after-write returns the newly written value.
- req_* changes while req_ready=0 are ignored.
- Reset mid-read or mid-response: transaction abandoned, rsp_valid drops immediately (async), memory cleared.
- Address wrap: none needed; every ADDR_W value is a valid word.

Optional Feature:
- Macro WR_RESP_EN.
- Defined: writes also use the response channel. Accepted write goes to RSP next cycle with rsp_valid=1 and rsp_rdata=written data; req_ready=0 until the response handshake. Adds output rsp_is_wr (1 for write responses, 0 for read, reset 0). wr_done still pulses.
- Undefined: writes complete silently as above; rsp_is_wr port does not exist.

Test Plan:
- Reset check: assert rst mid-sim -> rsp_valid=0, wr_done=0, rsp_rdata=0; then read each of addr 0..3 -> rdata 0x0 for all.
- Write 0xA,0x3,0xF,0x5 to addr 0..3 back-to-back with req_valid held -> accepted on 4 consecutive edges, wr_done pulses 4 cycles; read 0..3 with rsp_ready=1 -> 0xA,0x3,0xF,0x5, each rsp_valid exactly 2 cycles after acceptance.
- Back-pressure: read addr 2 (0xF), hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable at 0xF, req_ready=0 throughout; raise rsp_ready -> handshake, req_ready=1 next cycle.
- Read-after-write: write 0x9 to addr 1, immediately read addr 1 -> 0x9.
- Async reset during RD_WAIT (pulse rst between edges) -> rsp_valid stays 0, state IDLE, subsequent read of that address returns 0x0.
- With WR_RESP_EN: write 0x6 to addr 3 -> rsp_valid next cycle, rsp_rdata=0x6, rsp_is_wr=1; next read addr 3 -> rsp_rdata=0x6, rsp_is_wr=0.
